fsm_sar_scan: RTL and testbench



---
 rtl/fsm_sar_scan_pkg.sv | 21 ++
 rtl/fsm_sar_scan_ch_next.sv | 35 +++
 rtl/fsm_sar_scan.sv | 251 +++++++++++++++++++++++++
 tb/tb_fsm_sar_scan.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_sar_scan_pkg.sv
// fsm_sar_pkg: shared definitions for the SAR scan controller.
//   state_t  : controller state encoding
//   CH_W()   : width of a channel index, never less than one bit
//   CMP_KEEP : comparator level that keeps the bit under trial
package fsm_sar_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_TRIAL,
    ST_SETTLE,
    ST_STORE
  } state_t;

  localparam logic CMP_KEEP = 1'b1;

  function automatic int CH_W(input int numCh);
    return (numCh > 1) ? $clog2(numCh) : 1;
  endfunction

endpackage

// File: rtl/fsm_sar_scan_ch_next.sv
// sar_ch_next: combinational channel finder over an enable mask.
//   i_mask   : enabled channels
//   i_cur    : current channel index
//   o_next   : lowest enabled channel strictly above i_cur
//   o_wrap   : no enabled channel above i_cur (scan end)
//   o_lowest : lowest enabled channel of the whole mask (0 if mask empty)
module sar_ch_next #(
  parameter int NumCh = 4,
  parameter int ChW   = 2
) (
  input  logic [NumCh-1:0] i_mask,
  input  logic [ChW-1:0]   i_cur,
  output logic [ChW-1:0]   o_next,
  output logic             o_wrap,
  output logic [ChW-1:0]   o_lowest
);

  // Both searches walk from the top down so that the last hit, which is
  // the lowest matching index, is the one that sticks.
  always_comb begin
    o_next   = '0;
    o_wrap   = 1'b1;
    o_lowest = '0;
    for (int i = NumCh - 1; i >= 0; i--) begin
      if (i_mask[i]) begin
        o_lowest = ChW'(i);
      end
      if (i_mask[i] && (i > int'(i_cur))) begin
        o_next = ChW'(i);
        o_wrap = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fsm_sar_scan.sv
// fsm_sar_scan: successive-approximation ADC controller with a channel
// scan sequencer and a one-entry result holding register.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   start_i, mode_i     : start a scan; 0 = single scan, 1 = continuous
//   ch_mask_i           : enabled channels
//   cmp_i               : comparator, 1 = Vin >= Vdac
//   sample_o, dac_o     : track/hold switch and DAC code
//   ch_o                : analog mux select
//   result_o/_ch_o      : holding register contents
//   result_valid_o      : holding register full; result_ready_i accepts
//   busy_o, eoc_o       : not idle; end-of-scan pulse
//   overrun_o           : sticky flag, a result was dropped
module fsm_sar_scan
  import fsm_sar_pkg::*;
#(
  parameter int Width        = 8,
  parameter int NumCh        = 4,
  parameter int SettleCycles = 1,
  parameter int SampleCycles = 2,
  localparam int CW          = CH_W(NumCh)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [NumCh-1:0] ch_mask_i,
  input  logic             cmp_i,
  output logic             sample_o,
  output logic [Width-1:0] dac_o,
  output logic [CW-1:0]    ch_o,
  output logic [Width-1:0] result_o,
  output logic [CW-1:0]    result_ch_o,
  output logic             result_valid_o,
  input  logic             result_ready_i,
  output logic             busy_o,
  output logic             eoc_o,
  output logic             overrun_o
);

  localparam int KW          = $clog2(Width);
  localparam int CNT_MAX     = (SampleCycles > SettleCycles) ? SampleCycles : SettleCycles;
  localparam int CNT_W       = $clog2(CNT_MAX + 1);
  localparam int SETTLE_LAST = (SettleCycles > 0) ? SettleCycles - 1 : 0;

  state_t           r_state;
  state_t           w_nextState;
  logic [NumCh-1:0] r_mask;
  logic             r_mode;
  logic [CW-1:0]    r_ch;
  logic [KW-1:0]    r_bit;
  logic [Width-1:0] r_code;
  logic [CNT_W-1:0] r_cnt;
  logic [Width-1:0] r_result;
  logic [CW-1:0]    r_resultCh;
  logic             r_valid;
  logic             r_overrun;

  logic [CW-1:0]    w_next;
  logic             w_nextWrap;
  logic [CW-1:0]    w_scanLowest;
  logic [CW-1:0]    w_newNext;
  logic             w_newWrap;
  logic [CW-1:0]    w_newLowest;
  logic             w_unused;
  logic [Width-1:0] w_trialCode;
  logic             w_accept;
  logic             w_bitResolve;
  logic             w_storeLoad;
  logic             w_storeDrop;
  logic             w_storeExit;
  logic             w_relatch;

  // One finder walks the latched mask for the next channel of this scan;
  // the other looks at the live mask input for the first channel of a new
  // or wrapped scan, which must use the mask being latched right now.
  sar_ch_next #(.NumCh(NumCh), .ChW(CW)) u_scanNext (
    .i_mask   (r_mask),
    .i_cur    (r_ch),
    .o_next   (w_next),
    .o_wrap   (w_nextWrap),
    .o_lowest (w_scanLowest)
  );

  sar_ch_next #(.NumCh(NumCh), .ChW(CW)) u_newFirst (
    .i_mask   (ch_mask_i),
    .i_cur    (CW'(0)),
    .o_next   (w_newNext),
    .o_wrap   (w_newWrap),
    .o_lowest (w_newLowest)
  );

  // Each finder instance leaves some outputs unneeded here.
  assign w_unused = ^{w_scanLowest, w_newNext, w_newWrap};

  assign w_trialCode    = r_code | (Width'(1) << r_bit);
  assign w_accept       = r_valid & result_ready_i;
  assign ch_o           = r_ch;
  assign result_o       = r_result;
  assign result_ch_o    = r_resultCh;
  assign result_valid_o = r_valid;
  assign overrun_o      = r_overrun;
  assign busy_o         = (r_state != ST_IDLE);

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and output decode. STORE loads when the slot is empty or
  // is being drained this same cycle; otherwise single mode waits and
  // continuous mode throws the new result away so the scan keeps pace.
  always_comb begin
    w_nextState  = r_state;
    w_bitResolve = 1'b0;
    w_storeLoad  = 1'b0;
    w_storeDrop  = 1'b0;
    w_storeExit  = 1'b0;
    w_relatch    = 1'b0;
    sample_o     = 1'b0;
    dac_o        = '0;
    eoc_o        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i && (|ch_mask_i)) begin
          w_nextState = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        sample_o = 1'b1;
        if (r_cnt == CNT_W'(SampleCycles - 1)) begin
          w_nextState = ST_TRIAL;
        end
      end
      ST_TRIAL: begin
        dac_o = w_trialCode;
        if (SettleCycles == 0) begin
          w_bitResolve = 1'b1;
          w_nextState  = (r_bit == '0) ? ST_STORE : ST_TRIAL;
        end else begin
          w_nextState = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        dac_o = w_trialCode;
        if (r_cnt == CNT_W'(SETTLE_LAST)) begin
          w_bitResolve = 1'b1;
          w_nextState  = (r_bit == '0) ? ST_STORE : ST_TRIAL;
        end
      end
      ST_STORE: begin
        w_storeLoad = !r_valid || w_accept;
        w_storeDrop = !w_storeLoad && r_mode;
        w_storeExit = w_storeLoad || w_storeDrop;
        if (w_storeExit) begin
          if (!w_nextWrap) begin
            w_nextState = ST_SAMPLE;
          end else begin
            eoc_o = 1'b1;
            if (r_mode && mode_i) begin
              w_relatch   = 1'b1;
              w_nextState = (|ch_mask_i) ? ST_SAMPLE : ST_IDLE;
            end else begin
              w_nextState = ST_IDLE;
            end
          end
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Datapath: scan bookkeeping, successive-approximation register,
  // holding register and overrun flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mask     <= '0;
      r_mode     <= 1'b0;
      r_ch       <= '0;
      r_bit      <= '0;
      r_code     <= '0;
      r_cnt      <= '0;
      r_result   <= '0;
      r_resultCh <= '0;
      r_valid    <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_valid <= 1'b0;
      end
      if (w_storeLoad) begin
        r_valid    <= 1'b1;
        r_result   <= r_code;
        r_resultCh <= r_ch;
      end
      if (w_storeDrop) begin
        r_overrun <= 1'b1;
      end
      if (w_bitResolve) begin
        r_code[r_bit] <= (cmp_i == CMP_KEEP);
        if (r_bit != '0) begin
          r_bit <= r_bit - KW'(1);
        end
      end
      case (r_state)
        ST_IDLE: begin
          if (w_nextState == ST_SAMPLE) begin
            r_mask    <= ch_mask_i;
            r_mode    <= mode_i;
            r_ch      <= w_newLowest;
            r_overrun <= 1'b0;
            r_cnt     <= '0;
          end
        end
        ST_SAMPLE: begin
          r_code <= '0;
          r_bit  <= KW'(Width - 1);
          r_cnt  <= (r_cnt == CNT_W'(SampleCycles - 1)) ? '0 : r_cnt + CNT_W'(1);
        end
        ST_TRIAL: begin
          r_cnt <= '0;
        end
        ST_SETTLE: begin
          r_cnt <= w_bitResolve ? '0 : r_cnt + CNT_W'(1);
        end
        ST_STORE: begin
          if (w_storeExit) begin
            r_cnt <= '0;
            if (!w_nextWrap) begin
              r_ch <= w_next;
            end else begin
              r_mode <= mode_i;
              if (w_relatch) begin
                r_mask <= ch_mask_i;
                r_ch   <= w_newLowest;
              end
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_sar_scan.sv
// tb_fsm_sar_scan: self-checking bench for fsm_sar_scan with default
// parameters. A behavioural comparator turns dac_o into cmp_i from a
// per-channel input voltage table.
module tb_fsm_sar_scan;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       start_i = 1'b0;
  logic       mode_i = 1'b0;
  logic [3:0] ch_mask_i = '0;
  logic       cmp_i;
  logic       result_ready_i = 1'b0;
  logic       sample_o;
  logic [7:0] dac_o;
  logic [1:0] ch_o;
  logic [7:0] result_o;
  logic [1:0] result_ch_o;
  logic       result_valid_o;
  logic       busy_o;
  logic       eoc_o;
  logic       overrun_o;

  logic [7:0] vinTable [4];
  int         total = 0;
  int         bad = 0;
  int         eocCount = 0;
  int         chViol = 0;
  bit         chWatch = 0;
  logic [9:0] accQ [$];

  typedef struct {
    logic [3:0] mask;
    logic [7:0] vin;
    logic [7:0] expResult;
    logic [1:0] expCh;
    int         expLatency;
    bit         checkDac;
  } convVec_t;

  convVec_t   vecs [5];
  logic [7:0] expDac [8];
  logic [7:0] seenDac [8];

  fsm_sar_scan #(
    .Width(8), .NumCh(4), .SettleCycles(1), .SampleCycles(2)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .mode_i         (mode_i),
    .ch_mask_i      (ch_mask_i),
    .cmp_i          (cmp_i),
    .sample_o       (sample_o),
    .dac_o          (dac_o),
    .ch_o           (ch_o),
    .result_o       (result_o),
    .result_ch_o    (result_ch_o),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .busy_o         (busy_o),
    .eoc_o          (eoc_o),
    .overrun_o      (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  // Ideal comparator for whichever channel the mux currently selects.
  always_comb begin
    cmp_i = (vinTable[ch_o] >= dac_o);
  end

  // Mid-low-phase monitor: counts eoc pulses, logs accepted results and
  // flags any visit to a channel the scan test has masked off.
  always begin
    @(negedge clk_i);
    #2;
    if (!rst_i) begin
      if (eoc_o) eocCount++;
      if (result_valid_o && result_ready_i) accQ.push_back({result_ch_o, result_o});
      if (chWatch && busy_o && (ch_o == 2'd0 || ch_o == 2'd2)) chViol++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] mask, input logic mode);
    @(negedge clk_i);
    ch_mask_i = mask;
    mode_i    = mode;
    start_i   = 1'b1;
    @(negedge clk_i);
    start_i   = 1'b0;
  endtask

  task automatic waitIdle(input int maxCycles, input string name);
    int n;
    n = 0;
    while (busy_o && n < maxCycles) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput(name, {31'd0, busy_o}, 32'd0);
  endtask

  int         lat;
  int         nDac;
  logic [7:0] lastDac;

  initial begin
    vecs[0] = '{4'b0001, 8'hA5, 8'hA5, 2'd0, 19, 1'b1};
    vecs[1] = '{4'b0001, 8'h00, 8'h00, 2'd0, 19, 1'b0};
    vecs[2] = '{4'b0001, 8'hFF, 8'hFF, 2'd0, 19, 1'b0};
    vecs[3] = '{4'b0100, 8'h5A, 8'h5A, 2'd2, 19, 1'b0};
    vecs[4] = '{4'b1000, 8'h01, 8'h01, 2'd3, 19, 1'b0};
    expDac  = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    for (int i = 0; i < 4; i++) vinTable[i] = 8'h00;

    #1 rst_i = 1'b1;
    #1;
    checkOutput("reset outputs",
                {8'd0, sample_o, dac_o, ch_o, result_o, result_ch_o,
                 result_valid_o, busy_o, eoc_o, overrun_o}, 32'd0);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;

    // Single-channel conversions with an always-ready consumer.
    result_ready_i = 1'b1;
    for (int v = 0; v < 5; v++) begin
      vinTable[vecs[v].expCh] = vecs[v].vin;
      eocCount = 0;
      applyStimulus(vecs[v].mask, 1'b0);
      lat = 0;
      nDac = 0;
      lastDac = 8'h00;
      while (!result_valid_o && lat < 100) begin
        if (dac_o != 8'h00 && dac_o != lastDac) begin
          if (nDac < 8) seenDac[nDac] = dac_o;
          nDac++;
          lastDac = dac_o;
        end
        @(negedge clk_i);
        lat++;
      end
      checkOutput($sformatf("latency v%0d", v), lat, vecs[v].expLatency);
      checkOutput($sformatf("result v%0d", v), {24'd0, result_o}, {24'd0, vecs[v].expResult});
      checkOutput($sformatf("result_ch v%0d", v), {30'd0, result_ch_o}, {30'd0, vecs[v].expCh});
      checkOutput($sformatf("busy after v%0d", v), {31'd0, busy_o}, 32'd0);
      checkOutput($sformatf("eoc count v%0d", v), eocCount, 1);
      if (vecs[v].checkDac) begin
        checkOutput("dac trial count", nDac, 8);
        for (int i = 0; i < 8; i++) begin
          checkOutput($sformatf("dac trial %0d", i), {24'd0, seenDac[i]}, {24'd0, expDac[i]});
        end
      end
      repeat (2) @(negedge clk_i);
      vinTable[vecs[v].expCh] = 8'h00;
    end

    // Two-channel scan: only channels 1 and 3 may ever be selected.
    vinTable[1] = 8'h33;
    vinTable[3] = 8'hC4;
    accQ.delete();
    eocCount = 0;
    chViol = 0;
    chWatch = 1;
    applyStimulus(4'b1010, 1'b0);
    waitIdle(100, "scan idle");
    repeat (2) @(negedge clk_i);
    chWatch = 0;
    checkOutput("scan result count", accQ.size(), 2);
    checkOutput("scan first", {22'd0, (accQ.size() > 0) ? accQ[0] : 10'h3FF}, {22'd0, 2'd1, 8'h33});
    checkOutput("scan second", {22'd0, (accQ.size() > 1) ? accQ[1] : 10'h3FF}, {22'd0, 2'd3, 8'hC4});
    checkOutput("scan eoc count", eocCount, 1);
    checkOutput("scan masked ch visits", chViol, 0);

    // Single-mode backpressure: second result waits in STORE.
    vinTable[0] = 8'h12;
    vinTable[1] = 8'hE7;
    result_ready_i = 1'b0;
    accQ.delete();
    eocCount = 0;
    applyStimulus(4'b0011, 1'b0);
    repeat (50) @(negedge clk_i);
    checkOutput("stall valid", {31'd0, result_valid_o}, 32'd1);
    checkOutput("stall held result", {24'd0, result_o}, 32'h12);
    checkOutput("stall held ch", {30'd0, result_ch_o}, 32'd0);
    checkOutput("stall busy", {31'd0, busy_o}, 32'd1);
    checkOutput("stall no eoc yet", eocCount, 0);
    result_ready_i = 1'b1;
    #1;
    checkOutput("stall release eoc", {31'd0, eoc_o}, 32'd1);
    @(negedge clk_i);
    checkOutput("stall second result", {24'd0, result_o}, 32'hE7);
    checkOutput("stall second ch", {30'd0, result_ch_o}, 32'd1);
    checkOutput("stall second valid", {31'd0, result_valid_o}, 32'd1);
    checkOutput("stall busy after", {31'd0, busy_o}, 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    checkOutput("stall drained", {31'd0, result_valid_o}, 32'd0);
    checkOutput("stall accepted count", accQ.size(), 2);
    checkOutput("stall order", {22'd0, (accQ.size() > 1) ? accQ[0] : 10'h3FF}, {22'd0, 2'd0, 8'h12});
    checkOutput("stall no overrun", {31'd0, overrun_o}, 32'd0);

    // Continuous mode with a stuck consumer: later results are dropped.
    vinTable[0] = 8'h3C;
    result_ready_i = 1'b0;
    eocCount = 0;
    applyStimulus(4'b0001, 1'b1);
    repeat (45) @(negedge clk_i);
    checkOutput("cont overrun", {31'd0, overrun_o}, 32'd1);
    checkOutput("cont kept first", {24'd0, result_o}, 32'h3C);
    checkOutput("cont busy", {31'd0, busy_o}, 32'd1);
    mode_i = 1'b0;
    waitIdle(60, "cont stop idle");
    checkOutput("cont eoc count", eocCount, 3);
    checkOutput("cont overrun sticky", {31'd0, overrun_o}, 32'd1);
    checkOutput("cont still first", {24'd0, result_o}, 32'h3C);
    result_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    checkOutput("cont drained", {31'd0, result_valid_o}, 32'd0);
    vinTable[0] = 8'h77;
    applyStimulus(4'b0001, 1'b0);
    checkOutput("start clears overrun", {31'd0, overrun_o}, 32'd0);
    waitIdle(40, "post overrun idle");
    checkOutput("post overrun result", {24'd0, result_o}, 32'h77);

    // Asynchronous reset while trialling bit 3 of channel 2.
    vinTable[2] = 8'hA5;
    applyStimulus(4'b0100, 1'b0);
    repeat (10) @(negedge clk_i);
    checkOutput("pre-reset dac k3", {24'd0, dac_o}, 32'hA8);
    checkOutput("pre-reset ch", {30'd0, ch_o}, 32'd2);
    #1 rst_i = 1'b1;
    #1;
    checkOutput("mid reset outputs",
                {8'd0, sample_o, dac_o, ch_o, result_o, result_ch_o,
                 result_valid_o, busy_o, eoc_o, overrun_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    eocCount = 0;
    accQ.delete();
    repeat (30) @(negedge clk_i);
    checkOutput("after reset no eoc", eocCount, 0);
    checkOutput("after reset no valid", {31'd0, result_valid_o}, 32'd0);
    checkOutput("after reset idle", {31'd0, busy_o}, 32'd0);

    // A start with an empty mask must be ignored.
    applyStimulus(4'b0000, 1'b0);
    repeat (3) @(negedge clk_i);
    checkOutput("empty mask ignored", {31'd0, busy_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
